// File: rtl/fpu_add_zero_responder.sv
// Responder front end of the FPU add/subtract handshake: resolves NaN/Inf/zero operand pairs
// locally and forwards normal pairs to the arithmetic core. Option macro: SUBNORMAL_FLUSH_EN.
module fpu_add_zero_responder #(
    parameter int W       = 32,
    parameter int EW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         beg_FSM,
    input  logic         rst_FSM,
    input  logic [W-1:0] Data_X,
    input  logic [W-1:0] Data_Y,
    input  logic         add_subt,
    input  logic [1:0]   r_mode,
    output logic         ready,
    output logic [W-1:0] final_result_ieee,
    output logic         overflow_flag,
    output logic         underflow_flag,
    output logic         timeout_err,
    output logic         core_start,
    output logic [W-1:0] core_X,
    output logic [W-1:0] core_Y,
    output logic         core_add_subt,
    output logic [1:0]   core_r_mode,
    output logic         core_rst_FSM,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    input  logic         core_overflow,
    input  logic         core_underflow
);

    localparam int FW = W - 1 - EW;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CHECK, CORE, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ready_q, ready_d;
    logic [W-1:0]   result_q, result_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           tout_q, tout_d;
    logic           start_q, start_d;
    logic [W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic           cas_q, cas_d;
    logic [1:0]     crm_q, crm_d;
    logic           crst_q, crst_d;

    // Operand classification works on the latched copies that also feed the core.
    logic [EW-1:0] x_exp, y_exp;
    logic [FW-1:0] x_frac, y_frac;
    logic          x_s, y_s;
    logic          x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic          special;
    logic [W-1:0]  special_res;

    assign x_exp  = cx_q[W-2 -: EW];
    assign y_exp  = cy_q[W-2 -: EW];
    assign x_frac = cx_q[FW-1:0];
    assign y_frac = cy_q[FW-1:0];
    assign x_s    = cx_q[W-1];
    assign y_s    = cy_q[W-1] ^ cas_q;

    assign x_nan = (&x_exp) && (|x_frac);
    assign y_nan = (&y_exp) && (|y_frac);
    assign x_inf = (&x_exp) && !(|x_frac);
    assign y_inf = (&y_exp) && !(|y_frac);
`ifdef SUBNORMAL_FLUSH_EN
    assign x_zero = !(|x_exp);
    assign y_zero = !(|y_exp);
`else
    assign x_zero = !(|x_exp) && !(|x_frac);
    assign y_zero = !(|y_exp) && !(|y_frac);
`endif

    assign special = x_nan || y_nan || x_inf || y_inf || x_zero || y_zero;

    always_comb begin
        special_res = QNAN;
        if (x_nan || y_nan) begin
            special_res = QNAN;
        end else if (x_inf && y_inf && (x_s != y_s)) begin
            special_res = QNAN;
        end else if (x_inf) begin
            special_res = {x_s, {EW{1'b1}}, {FW{1'b0}}};
        end else if (y_inf) begin
            special_res = {y_s, {EW{1'b1}}, {FW{1'b0}}};
        end else if (x_zero && y_zero) begin
            // Round toward -inf is the only mode where +0 + -0 yields -0.
            special_res = {(crm_q == 2'b11) ? (x_s | y_s) : (x_s & y_s), {(W-1){1'b0}}};
        end else if (x_zero) begin
            special_res = {y_s, cy_q[W-2:0]};
        end else if (y_zero) begin
            special_res = cx_q;
        end
    end

    // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        tout_d   = tout_q;
        start_d  = 1'b0;
        cx_d     = cx_q;
        cy_d     = cy_q;
        cas_d    = cas_q;
        crm_d    = crm_q;
        crst_d   = rst_FSM;

        if (rst_FSM) begin
            state_d = IDLE;
            ready_d = 1'b0;
            tout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (beg_FSM) begin
                    cx_d    = Data_X;
                    cy_d    = Data_Y;
                    cas_d   = add_subt;
                    crm_d   = r_mode;
                    state_d = CHECK;
                end
                CHECK: if (special) begin
                    result_d = special_res;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = CORE;
                end
                CORE: if (core_done) begin
                    result_d = core_result;
                    ovf_d    = core_overflow;
                    unf_d    = core_underflow;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    result_d = QNAN;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    tout_d   = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            tout_q   <= 1'b0;
            start_q  <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            cas_q    <= 1'b0;
            crm_q    <= 2'b00;
            crst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            tout_q   <= tout_d;
            start_q  <= start_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            cas_q    <= cas_d;
            crm_q    <= crm_d;
            crst_q   <= crst_d;
        end
    end

    assign ready             = ready_q;
    assign final_result_ieee = result_q;
    assign overflow_flag     = ovf_q;
    assign underflow_flag    = unf_q;
    assign timeout_err       = tout_q;
    assign core_start        = start_q;
    assign core_X            = cx_q;
    assign core_Y            = cy_q;
    assign core_add_subt     = cas_q;
    assign core_r_mode       = crm_q;
    assign core_rst_FSM      = crst_q;

endmodule

// File: tb/tb_fpu_add_zero_responder.sv
// Directed bench for fpu_add_zero_responder: special-operand paths, core handshake,
// timeout and rst_FSM abort. Cycle c is the interval after the c-th edge since beg_FSM.
module tb_fpu_add_zero_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        beg_FSM, rst_FSM;
    logic [31:0] Data_X, Data_Y;
    logic        add_subt;
    logic [1:0]  r_mode;
    logic        ready;
    logic [31:0] final_result_ieee;
    logic        overflow_flag, underflow_flag, timeout_err;
    logic        core_start;
    logic [31:0] core_X, core_Y;
    logic        core_add_subt;
    logic [1:0]  core_r_mode;
    logic        core_rst_FSM;
    logic        core_done;
    logic [31:0] core_result;
    logic        core_overflow, core_underflow;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    fpu_add_zero_responder #(.W(32), .EW(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .beg_FSM(beg_FSM), .rst_FSM(rst_FSM),
        .Data_X(Data_X), .Data_Y(Data_Y), .add_subt(add_subt), .r_mode(r_mode),
        .ready(ready), .final_result_ieee(final_result_ieee),
        .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
        .timeout_err(timeout_err), .core_start(core_start),
        .core_X(core_X), .core_Y(core_Y), .core_add_subt(core_add_subt),
        .core_r_mode(core_r_mode), .core_rst_FSM(core_rst_FSM),
        .core_done(core_done), .core_result(core_result),
        .core_overflow(core_overflow), .core_underflow(core_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (CHECK).
    task automatic start(input logic [31:0] x, input logic [31:0] y,
                         input logic as, input logic [1:0] rm);
        Data_X = x; Data_Y = y; add_subt = as; r_mode = rm;
        beg_FSM = 1'b1;
        tick();
        beg_FSM = 1'b0;
    endtask

    task automatic clear(input string tag);
        rst_FSM = 1'b1;
        tick();
        check({tag, "_clr_ready"}, 32'(ready), 32'h0);
        check({tag, "_clr_corerst"}, 32'(core_rst_FSM), 32'h1);
        check({tag, "_clr_tout"}, 32'(timeout_err), 32'h0);
        rst_FSM = 1'b0;
        tick();
        check({tag, "_clr_corerst_off"}, 32'(core_rst_FSM), 32'h0);
    endtask

    task automatic special(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic as, input logic [1:0] rm, input logic [31:0] exp);
        start(x, y, as, rm);
        check({tag, "_c1_ready"}, 32'(ready), 32'h0);
        tick();
        check({tag, "_ready"}, 32'(ready), 32'h1);
        check({tag, "_result"}, final_result_ieee, exp);
        check({tag, "_flags"}, {30'h0, overflow_flag, underflow_flag}, 32'h0);
        check({tag, "_nostart"}, 32'(core_start), 32'h0);
        clear(tag);
    endtask

    initial begin
        rst = 1'b1; beg_FSM = 1'b0; rst_FSM = 1'b0;
        Data_X = '0; Data_Y = '0; add_subt = 1'b0; r_mode = 2'b00;
        core_done = 1'b0; core_result = '0; core_overflow = 1'b0; core_underflow = 1'b0;
        tick(); tick();
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_result", final_result_ieee, 32'h0);
        check("rst_corex", core_X, 32'h0);
        check("rst_misc", {27'h0, core_start, core_rst_FSM, timeout_err, overflow_flag, underflow_flag}, 32'h0);
        rst = 1'b0;
        tick();

        // Normal pair through the core, done 10 cycles after core_start
        start(32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b00);
        check("core_c1_start", 32'(core_start), 32'h0);
        tick();
        check("core_c2_start", 32'(core_start), 32'h1);
        check("core_c2_x", core_X, 32'h3F80_0000);
        check("core_c2_y", core_Y, 32'h4000_0000);
        core_result = 32'h4040_0000; core_overflow = 1'b1;
        tick();
        check("core_c3_start", 32'(core_start), 32'h0);
        for (int i = 0; i < 9; i++) tick();
        check("core_c12_ready", 32'(ready), 32'h0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("core_c13_ready", 32'(ready), 32'h1);
        check("core_c13_result", final_result_ieee, 32'h4040_0000);
        check("core_c13_ovf", 32'(overflow_flag), 32'h1);
        core_overflow = 1'b0;
        start(32'h0, 32'h0, 1'b1, 2'b11);
        tick(); tick();
        check("core_hold_ready", 32'(ready), 32'h1);
        check("core_hold_result", final_result_ieee, 32'h4040_0000);
        clear("core");

        special("yzero", 32'h3F80_0000, 32'h0000_0000, 1'b1, 2'b00, 32'h3F80_0000);
        special("xzero", 32'h0000_0000, 32'h3F80_0000, 1'b1, 2'b00, 32'hBF80_0000);
        special("zz_rne", 32'h0000_0000, 32'h0000_0000, 1'b1, 2'b00, 32'h0000_0000);
        special("zz_rmi", 32'h0000_0000, 32'h0000_0000, 1'b1, 2'b11, 32'h8000_0000);
        special("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 2'b00, QNAN);
        special("inf_nan", 32'h7F80_0000, 32'h7FC0_0001, 1'b0, 2'b00, QNAN);
        special("one_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 2'b00, 32'hFF80_0000);
        special("inf_one", 32'hFF80_0000, 32'h3F80_0000, 1'b0, 2'b01, 32'hFF80_0000);

        // Subnormal X against 1.0
`ifdef SUBNORMAL_FLUSH_EN
        special("subn", 32'h0000_0001, 32'h3F80_0000, 1'b0, 2'b00, 32'h3F80_0000);
`else
        start(32'h0000_0001, 32'h3F80_0000, 1'b0, 2'b00);
        tick();
        check("subn_start", 32'(core_start), 32'h1);
        check("subn_ready", 32'(ready), 32'h0);
        core_result = 32'h3F80_0001; core_underflow = 1'b1; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("subn_result", final_result_ieee, 32'h3F80_0001);
        check("subn_unf", 32'(underflow_flag), 32'h1);
        core_underflow = 1'b0;
        clear("subn");
`endif

        // Core never answers: ready exactly TIMEOUT+1 cycles after the first CORE cycle
        start(32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b00);
        tick();
        for (int i = 0; i < 255; i++) tick();
        check("tout_c257_ready", 32'(ready), 32'h0);
        tick();
        check("tout_c258_ready", 32'(ready), 32'h1);
        check("tout_err", 32'(timeout_err), 32'h1);
        check("tout_result", final_result_ieee, QNAN);
        clear("tout");

        // rst_FSM aborts the core wait; a late core_done is ignored
        start(32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) tick();
        rst_FSM = 1'b1;
        tick();
        check("abort_corerst", 32'(core_rst_FSM), 32'h1);
        check("abort_ready", 32'(ready), 32'h0);
        rst_FSM = 1'b0;
        core_result = 32'hDEAD_BEEF; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("abort_late_ready", 32'(ready), 32'h0);
        check("abort_late_result", final_result_ieee, QNAN);
        check("abort_corerst_off", 32'(core_rst_FSM), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
